// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed seven-segment scanner with a dark guard
// interval per digit, leading-zero blanking and frame-consistent double buffering.
module seg7_scan_driver #(
  parameter int NUM_DIGITS          = 8,
  parameter int DIGIT_PERIOD_CYCLES = 100000,
  parameter int GUARD_CYCLES        = 2000,
  parameter bit ANODE_ACTIVE_LOW    = 1'b1,
  parameter bit SEG_ACTIVE_LOW      = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_enable,
  input  logic [4*NUM_DIGITS-1:0]   i_data,
  input  logic                      i_valid,
  input  logic [NUM_DIGITS-1:0]     i_dp_mask,
  input  logic                      i_blank_lz,
  output logic [NUM_DIGITS-1:0]     o_anode,
  output logic [6:0]                o_seg,
  output logic                      o_dp,
  output logic                      o_frame_tick
);

  localparam int ON_CYCLES = DIGIT_PERIOD_CYCLES - GUARD_CYCLES;
  localparam int CNT_W     = (DIGIT_PERIOD_CYCLES > 1) ? $clog2(DIGIT_PERIOD_CYCLES) : 1;
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]      ON_PENULT  = CNT_W'((ON_CYCLES > 1) ? ON_CYCLES - 2 : 0);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_ONE  = NUM_DIGITS'(1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF  = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF    = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF     = SEG_ACTIVE_LOW;

  // At least one dark cycle is needed so the active register settles before digit 0 lights.
  generate
    if (GUARD_CYCLES < 1 || GUARD_CYCLES >= DIGIT_PERIOD_CYCLES) begin : g_bad_timing
      $error("seg7_scan_driver: GUARD_CYCLES must be in 1..DIGIT_PERIOD_CYCLES-1");
    end
  endgenerate

  typedef enum logic [1:0] {S_OFF, S_GUARD, S_ON} state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [NUM_DIGITS-1:0]   r_anode;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    r_tick;

  logic [4*NUM_DIGITS-1:0] r_sh_data;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic                    r_sh_blank_lz;
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_act_data;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic                    r_act_blank_lz;

  logic [3:0]              w_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [3:0]              w_cur_nib;
  logic [6:0]              w_seg_on;
  logic [NUM_DIGITS-1:0]   w_anode_on;
  logic                    w_dp_on;
  logic                    w_frame_start;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_glyph = 7'h3F;
      4'h1:    hex_glyph = 7'h06;
      4'h2:    hex_glyph = 7'h5B;
      4'h3:    hex_glyph = 7'h4F;
      4'h4:    hex_glyph = 7'h66;
      4'h5:    hex_glyph = 7'h6D;
      4'h6:    hex_glyph = 7'h7D;
      4'h7:    hex_glyph = 7'h07;
      4'h8:    hex_glyph = 7'h7F;
      4'h9:    hex_glyph = 7'h6F;
      4'hA:    hex_glyph = 7'h77;
      4'hB:    hex_glyph = 7'h7C;
      4'hC:    hex_glyph = 7'h39;
      4'hD:    hex_glyph = 7'h5E;
      4'hE:    hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  // A digit is blank when it and every more significant nibble are zero; digit 0 always shows.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_nib[gi] = r_act_data[4*gi +: 4];
      if (gi == 0) begin : g_lsd
        assign w_blank[gi] = 1'b0;
      end else begin : g_upper
        assign w_blank[gi] = r_act_blank_lz & (r_act_data[4*NUM_DIGITS-1:4*gi] == '0);
      end
    end
  endgenerate

  assign w_cur_nib  = w_nib[r_idx];
  assign w_seg_on   = w_blank[r_idx] ? SEG_OFF : (hex_glyph(w_cur_nib) ^ SEG_OFF);
  assign w_anode_on = (ANODE_ONE << r_idx) ^ ANODE_OFF;
  assign w_dp_on    = r_act_dp[r_idx] ^ DP_OFF;

  // Edge that starts slot 0: leaving OFF, or wrapping past the last digit.
  assign w_frame_start = i_enable &
                         ((r_state == S_OFF) |
                          ((r_state == S_ON) & (r_cnt == ON_LAST) & (r_idx == IDX_LAST)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_data      <= '0;
      r_sh_dp        <= '0;
      r_sh_blank_lz  <= 1'b0;
      r_pending      <= 1'b0;
      r_act_data     <= '0;
      r_act_dp       <= '0;
      r_act_blank_lz <= 1'b0;
    end else if (w_frame_start) begin
      if (i_valid) begin
        r_act_data     <= i_data;
        r_act_dp       <= i_dp_mask;
        r_act_blank_lz <= i_blank_lz;
        r_sh_data      <= i_data;
        r_sh_dp        <= i_dp_mask;
        r_sh_blank_lz  <= i_blank_lz;
      end else if (r_pending) begin
        r_act_data     <= r_sh_data;
        r_act_dp       <= r_sh_dp;
        r_act_blank_lz <= r_sh_blank_lz;
      end
      r_pending <= 1'b0;
    end else if (i_valid) begin
      r_sh_data     <= i_data;
      r_sh_dp       <= i_dp_mask;
      r_sh_blank_lz <= i_blank_lz;
      r_pending     <= 1'b1;
    end
  end

  // Outputs are loaded together with the state they belong to, so they line up with it.
  always_ff @(posedge clk) begin
    if (rst || !i_enable) begin
      r_state <= S_OFF;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_anode <= ANODE_OFF;
      r_seg   <= SEG_OFF;
      r_dp    <= DP_OFF;
      r_tick  <= 1'b0;
    end else begin
      r_anode <= ANODE_OFF;
      r_seg   <= SEG_OFF;
      r_dp    <= DP_OFF;
      r_tick  <= 1'b0;
      case (r_state)
        S_OFF: begin
          r_state <= S_GUARD;
          r_cnt   <= '0;
          r_idx   <= '0;
        end
        S_GUARD: begin
          if (r_cnt == GUARD_LAST) begin
            r_state <= S_ON;
            r_cnt   <= '0;
            r_anode <= w_anode_on;
            r_seg   <= w_seg_on;
            r_dp    <= w_dp_on;
            r_tick  <= (r_idx == IDX_LAST) && (ON_CYCLES == 1);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ON: begin
          if (r_cnt == ON_LAST) begin
            r_state <= S_GUARD;
            r_cnt   <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_anode <= w_anode_on;
            r_seg   <= w_seg_on;
            r_dp    <= w_dp_on;
            r_tick  <= (r_idx == IDX_LAST) && (r_cnt == ON_PENULT);
          end
        end
        default: begin
          r_state <= S_OFF;
          r_cnt   <= '0;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign o_anode      = r_anode;
  assign o_seg        = r_seg;
  assign o_dp         = r_dp;
  assign o_frame_tick = r_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: per-frame digit expectations are queued at each frame
// tick and compared slot by slot as the scanner lights each digit.
module tb_seg7_scan_driver;

  localparam int N = 8;
  localparam int P = 8;
  localparam int G = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_enable;
  logic [4*N-1:0] i_data;
  logic          i_valid;
  logic [N-1:0]  i_dp_mask;
  logic          i_blank_lz;
  logic [N-1:0]  o_anode;
  logic [6:0]    o_seg;
  logic          o_dp;
  logic          o_frame_tick;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS(N),
    .DIGIT_PERIOD_CYCLES(P),
    .GUARD_CYCLES(G),
    .ANODE_ACTIVE_LOW(1'b1),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_enable(i_enable),
    .i_data(i_data),
    .i_valid(i_valid),
    .i_dp_mask(i_dp_mask),
    .i_blank_lz(i_blank_lz),
    .o_anode(o_anode),
    .o_seg(o_seg),
    .o_dp(o_dp),
    .o_frame_tick(o_frame_tick)
  );

  typedef struct packed {
    logic [7:0] anode;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  int total = 0;
  int bad   = 0;

  slot_t exp_q[$];
  slot_t cur_exp;
  bit    cur_ok = 1'b0;
  bit    mon_on = 1'b0;
  logic [7:0] prev_anode = 8'hFF;
  int    on_len = 0;
  int    since_tick = 0;
  bit    tick_seen = 1'b0;

  logic [6:0] lit_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [31:0] d, input logic blz, input int n);
    logic [31:0] upper;
    upper = d >> (4 * n);
    if (blz && n != 0 && upper == 32'h0) return 7'h7F;
    return ~lit_tab[upper[3:0]];
  endfunction

  function automatic logic [7:0] exp_anode(input int n);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << n);
  endfunction

  task automatic push_frame(input logic [31:0] d, input logic [7:0] dp, input logic blz);
    slot_t s;
    for (int n = 0; n < N; n++) begin
      s.anode = exp_anode(n);
      s.seg   = exp_seg(d, blz, n);
      s.dp    = ~dp[n];
      exp_q.push_back(s);
    end
  endtask

  // Called at a negedge; strobes i_valid for exactly one rising edge.
  task automatic load(input logic [31:0] d, input logic [7:0] dp, input logic blz);
    i_data     = d;
    i_dp_mask  = dp;
    i_blank_lz = blz;
    i_valid    = 1'b1;
    @(negedge clk);
    i_valid    = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_frame_tick && n < 200);
    chk_eq(tag, o_frame_tick, 1'b1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk_eq({tag, "_anode"}, o_anode, 8'hFF);
    chk_eq({tag, "_seg"}, o_seg, 7'h7F);
    chk_eq({tag, "_dp"}, o_dp, 1'b1);
    chk_eq({tag, "_tick"}, o_frame_tick, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (o_anode !== 8'hFF) begin
        if (prev_anode === 8'hFF) begin
          on_len = 0;
          cur_ok = (exp_q.size() > 0);
          if (cur_ok) cur_exp = exp_q.pop_front();
        end
        on_len++;
        if (cur_ok) begin
          chk_eq("slot_anode", o_anode, cur_exp.anode);
          chk_eq("slot_seg", o_seg, cur_exp.seg);
          chk_eq("slot_dp", o_dp, cur_exp.dp);
        end
      end else begin
        chk_eq("dark_seg", o_seg, 7'h7F);
        chk_eq("dark_dp", o_dp, 1'b1);
        if (prev_anode !== 8'hFF && cur_ok) chk_eq("slot_len", on_len, P - G);
        cur_ok = 1'b0;
      end
      prev_anode = o_anode;
      if (rst || !i_enable) begin
        tick_seen  = 1'b0;
        since_tick = 0;
      end else begin
        since_tick++;
        if (o_frame_tick) begin
          if (tick_seen) chk_eq("tick_period", since_tick, N * P);
          tick_seen  = 1'b1;
          since_tick = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    i_enable   = 1'b0;
    i_valid    = 1'b0;
    i_data     = '0;
    i_dp_mask  = '0;
    i_blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    mon_on = 1'b1;
    rst    = 1'b0;
    @(negedge clk);

    // Load while dark, then enable: two dark guard cycles precede digit 0.
    load(32'h0123_ABCD, 8'h00, 1'b0);
    i_enable = 1'b1;
    @(negedge clk);
    chk_eq("first_guard0", o_anode, 8'hFF);
    @(negedge clk);
    chk_eq("first_guard1", o_anode, 8'hFF);
    @(negedge clk);
    chk_eq("first_on", o_anode, 8'hFE);

    wait_tick("tick_a");
    push_frame(32'h0123_ABCD, 8'h00, 1'b0);
    repeat (5) @(negedge clk);
    load(32'h0000_00F0, 8'h00, 1'b1);

    wait_tick("tick_b");
    push_frame(32'h0000_00F0, 8'h00, 1'b1);
    repeat (5) @(negedge clk);
    load(32'h0000_0000, 8'h00, 1'b1);

    // Two strobes inside the frame that shows all-zero: only the second may appear later.
    wait_tick("tick_c");
    push_frame(32'h0000_0000, 8'h00, 1'b1);
    repeat (5) @(negedge clk);
    load(32'h1111_1111, 8'h00, 1'b0);
    repeat (10) @(negedge clk);
    load(32'h2222_2222, 8'h00, 1'b0);

    wait_tick("tick_d");
    push_frame(32'h2222_2222, 8'h00, 1'b0);
    repeat (5) @(negedge clk);
    load(32'h0123_ABCD, 8'h81, 1'b0);

    wait_tick("tick_e");
    push_frame(32'h0123_ABCD, 8'h81, 1'b0);

    // Strobe exactly on the frame-boundary edge: the new frame shows it at once.
    wait_tick("tick_f");
    i_data     = 32'h89AB_CDEF;
    i_dp_mask  = 8'h00;
    i_blank_lz = 1'b0;
    i_valid    = 1'b1;
    push_frame(32'h89AB_CDEF, 8'h00, 1'b0);
    @(negedge clk);
    i_valid = 1'b0;

    // Drop enable while digit 1 is lit.
    wait_tick("tick_g");
    wait_tick("tick_h");
    repeat (12) @(negedge clk);
    chk_eq("pre_dis_anode", o_anode, 8'hFD);
    i_enable = 1'b0;
    @(negedge clk);
    chk_reset_outs("disabled");
    repeat (3) @(negedge clk);

    // Re-enable, leave a load pending, then reset mid-frame.
    i_enable = 1'b1;
    wait_tick("tick_i");
    repeat (12) @(negedge clk);
    load(32'h3333_3333, 8'hFF, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("restart_guard0", o_anode, 8'hFF);
    @(negedge clk);
    chk_eq("restart_guard1", o_anode, 8'hFF);
    @(negedge clk);
    chk_eq("restart_on", o_anode, 8'hFE);
    chk_eq("restart_seg", o_seg, 7'h40);
    chk_eq("restart_dp", o_dp, 1'b1);

    wait_tick("tick_j");
    push_frame(32'h0000_0000, 8'h00, 1'b0);
    wait_tick("tick_k");
    repeat (3) @(negedge clk);
    chk_eq("queue_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
